// File: rtl/logic_unit_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter_pkg
// Description : Shared op codes, FSM encoding and helpers for the logic-unit
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_arbiter_pkg;

  localparam int LU_DW = 16;
  localparam int LU_OPW = 2;

  localparam logic [LU_OPW-1:0] LU_OP_ZERO = 2'b00;
  localparam logic [LU_OPW-1:0] LU_OP_OR   = 2'b01;
  localparam logic [LU_OPW-1:0] LU_OP_XOR  = 2'b10;
  localparam logic [LU_OPW-1:0] LU_OP_AND  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_e;

endpackage : logic_unit_arbiter_pkg
`default_nettype wire

// File: rtl/logic_unit_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter_rr_pick
// Description : Combinational round-robin picker: first set request at or
//               above ptr_i, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter_rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW:0]   off;
  logic [IDW:0]   sum;

  // Rotate so that bit 0 of rot is the requester at ptr_i.
  always_comb begin
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[N-1:0];
  end

  always_comb begin
    off   = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = (IDW+1)'(k);
        any_o = 1'b1;
      end
    end
  end

  always_comb begin
    sum = {1'b0, ptr_i} + off;
    if (sum >= (IDW+1)'(N)) begin
      sum = sum - (IDW+1)'(N);
    end
    idx_o   = sum[IDW-1:0];
    grant_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule : logic_unit_arbiter_rr_pick
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter
// Description : Round-robin arbiter sharing one external 16-bit logic unit
//               between NUM_REQ requesters, one transaction in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [LU_DW*NUM_REQ-1:0]    req_a,
  input  logic [LU_DW*NUM_REQ-1:0]    req_b,
  input  logic [LU_OPW*NUM_REQ-1:0]   req_op,
  output logic [LU_DW-1:0]            lu_a,
  output logic [LU_DW-1:0]            lu_b,
  output logic [LU_OPW-1:0]           lu_op,
  input  logic [LU_DW-1:0]            lu_out,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [IDW-1:0]              rsp_id,
  output logic [LU_DW-1:0]            rsp_data,
  output logic                        busy
);

  arb_state_e          state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [LU_DW-1:0]    lu_a_q, lu_a_d;
  logic [LU_DW-1:0]    lu_b_q, lu_b_d;
  logic [LU_OPW-1:0]   lu_op_q, lu_op_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic [LU_DW-1:0]    rsp_data_q, rsp_data_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IDW-1:0]      pick_idx;
  logic                pick_any;
  logic [LU_DW-1:0]    sel_a;
  logic [LU_DW-1:0]    sel_b;
  logic [LU_OPW-1:0]   sel_op;

  logic_unit_arbiter_rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // One-hot operand mux driven by the picker's grant.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_a  = req_a[LU_DW*i +: LU_DW];
        sel_b  = req_b[LU_DW*i +: LU_DW];
        sel_op = req_op[LU_OPW*i +: LU_OPW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lu_a_d      = lu_a_q;
    lu_b_d      = lu_b_q;
    lu_op_d     = lu_op_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          // Gated by rst_n so ready stays low while reset is held.
          req_ready = pick_grant & {NUM_REQ{rst_n}};
          lu_a_d    = sel_a;
          lu_b_d    = sel_b;
          lu_op_d   = sel_op;
          rsp_id_d  = pick_idx;
          rr_ptr_d  = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = lu_out;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lu_a_q      <= '0;
      lu_b_q      <= '0;
      lu_op_q     <= LU_OP_ZERO;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lu_a_q      <= lu_a_d;
      lu_b_q      <= lu_b_d;
      lu_op_q     <= lu_op_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign lu_a      = lu_a_q;
  assign lu_b      = lu_b_q;
  assign lu_op     = lu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);

endmodule : logic_unit_arbiter
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_arbiter
// Description : Directed self-checking bench for logic_unit_arbiter with a
//               behavioural logic unit on the lu_* side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;

  localparam int NUM_REQ = 2;
  localparam int IDW     = 1;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [16*NUM_REQ-1:0]   req_a;
  logic [16*NUM_REQ-1:0]   req_b;
  logic [2*NUM_REQ-1:0]    req_op;
  logic [15:0]             lu_a;
  logic [15:0]             lu_b;
  logic [1:0]              lu_op;
  logic [15:0]             lu_out;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [15:0]             rsp_data;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  logic_unit_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_op     (lu_op),
    .lu_out    (lu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // External logic unit seen by the arbiter.
  always_comb begin
    case (lu_op)
      2'b01:   lu_out = lu_a | lu_b;
      2'b10:   lu_out = lu_a ^ lu_b;
      2'b11:   lu_out = lu_a & lu_b;
      default: lu_out = 16'h0000;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op);
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    req_op[2*id +: 2]  = op;
  endtask

  // Full transaction from an IDLE cycle; returns in the next IDLE cycle.
  task automatic run_one(input string tag, input int id, input logic [15:0] a,
                         input logic [15:0] b, input logic [1:0] op,
                         input logic [15:0] exp);
    set_req(id, a, b, op);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    #2;
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
    tick();
    req_valid = '0;
    #2;
    check({tag, "_exec_busy"}, 32'(busy), 32'd1);
    check({tag, "_exec_lu_a"}, 32'(lu_a), 32'(a));
    tick();
    #2;
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #2;
    check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1:0] exp_grant;
    int         exp_id;
    logic [15:0] exp_data;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_lu_a", 32'(lu_a), 32'd0);
    check("rst_lu_op", 32'(lu_op), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request and op coverage on requester 0.
    run_one("or",   0, 16'h00F0, 16'h0FF0, 2'b01, 16'h0FF0);
    run_one("xor",  0, 16'h00F0, 16'h0FF0, 2'b10, 16'h0F00);
    run_one("and",  0, 16'h00F0, 16'h0FF0, 2'b11, 16'h00F0);
    run_one("zero", 0, 16'h00F0, 16'h0FF0, 2'b00, 16'h0000);

    // Round robin with both requesters held valid from reset.
    rst_n = 1'b0;
    set_req(0, 16'h1234, 16'h00FF, 2'b10);
    set_req(1, 16'hF0F0, 16'hFF00, 2'b11);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    check("rr_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id    = k % 2;
      exp_grant = (exp_id == 0) ? 2'b01 : 2'b10;
      exp_data  = (exp_id == 0) ? 16'h12CB : 16'hF000;
      #2;
      check("rr_grant", 32'(req_ready), 32'(exp_grant));
      tick();
      tick();
      #2;
      check("rr_rsp_id", 32'(rsp_id), 32'(exp_id));
      check("rr_rsp_data", 32'(rsp_data), 32'(exp_data));
      tick();
      if (k == 3) req_valid = '0;
    end
    rsp_ready = 1'b0;

    // Backpressure on requester 1 while requester 0 waits.
    req_valid = 2'b10;
    #2;
    check("bp_grant", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b01;
    tick();
    for (int c = 0; c < 5; c++) begin
      #2;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'hF000);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    #2;
    check("bp_hold_valid", 32'(rsp_valid), 32'd1);
    tick();
    rsp_ready = 1'b0;
    #2;
    check("bp_acc_valid", 32'(rsp_valid), 32'd0);
    check("bp_acc_busy", 32'(busy), 32'd0);
    check("bp_pending_grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;

    // Reset asserted in EXEC discards the transaction.
    #2;
    check("rx_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rx_busy", 32'(busy), 32'd0);
    check("rx_valid", 32'(rsp_valid), 32'd0);
    check("rx_lu_a", 32'(lu_a), 32'd0);
    tick();
    tick();
    check("rx_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    run_one("rx_req1", 1, 16'hAAAA, 16'h5555, 2'b01, 16'hFFFF);

    // Pointer wrapped to 0; req1 withdrawn while busy gets nothing.
    set_req(0, 16'h0F0F, 16'h00FF, 2'b11);
    req_valid = 2'b11;
    #2;
    check("wd_grant0", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b10;
    #2;
    check("wd_exec_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    #2;
    check("wd_rsp_id", 32'(rsp_id), 32'd0);
    check("wd_rsp_data", 32'(rsp_data), 32'h000F);
    tick();
    #2;
    check("wd_idle_ready", 32'(req_ready), 32'd0);
    check("wd_idle_busy", 32'(busy), 32'd0);
    tick();
    #2;
    check("wd_no_grant_busy", 32'(busy), 32'd0);
    check("wd_no_rsp", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_logic_unit_arbiter
`default_nettype wire

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one combinational 16-bit logic unit (ops: zero/OR/XOR/AND) between NUM_REQ requesters.
- Round-robin grant, registered operand issue, registered result returned with a valid/ready response handshake.
- Sits between the requesting units and the logic unit. One transaction in flight at a time.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- IDW, 1, width of the requester-ID fields; must be at least ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  16*NUM_REQ  operand A, packed; slice i is [16*i+15:16*i].
- req_b  in  16*NUM_REQ  operand B, packed as for req_a.
- req_op  in  2*NUM_REQ  op code, packed; 00 zero, 01 OR, 10 XOR, 11 AND.
- lu_a  out  16  operand A to the logic unit.
- lu_b  out  16  operand B to the logic unit.
- lu_op  out  2  op code to the logic unit.
- lu_out  in  16  logic unit result (combinational from lu_a/lu_b/lu_op).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  16  result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rr_ptr=0; lu_a/lu_b/rsp_data=16'h0000; lu_op=2'b00; rsp_id=0; rsp_valid=0; req_ready=0; busy=0. Any in-flight transaction is discarded, with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no req_valid is set, stay in IDLE.
  - Otherwise pick the winner i: the first set req_valid bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[i]=1 combinationally in the same cycle. Handshake occurs when req_valid[i]&req_ready[i].
  - On the edge: latch req_a[i], req_b[i], req_op[i] into lu_a/lu_b/lu_op; latch rsp_id=i; set rr_ptr=(i+1) mod NUM_REQ; go to EXEC.
- req_ready is 0 in EXEC and RESP.
- Requester rule: hold valid and operands stable until ready. Dropping valid before ready is legal and causes no grant.
- EXEC: one cycle. The lu_* registers are stable. On the edge, rsp_data<=lu_out; rsp_valid<=1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_data stable until rsp_ready=1.
  - On the edge where rsp_valid&rsp_ready, clear rsp_valid and go to IDLE.
  - lu_* registers hold their last values; rsp_data keeps its last value after it is consumed.
- Latency: handshake at edge T; rsp_valid=1 from edge T+1 (visible in cycle T+1); earliest response accept at edge T+2; next grant possible at edge T+3.
- Op 00 always returns 16'h0000 regardless of operands; the logic unit produces this and the arbiter does not special-case it.
- Fairness: a continuously requesting agent waits at most NUM_REQ-1 transactions.
- A request arriving while busy is held off by ready=0 and arbitrated in the next IDLE cycle.
- rr_ptr wrap: after granting NUM_REQ-1, rr_ptr=0.
- rsp_ready=1 while not in RESP is ignored.
- Reset asserted mid-EXEC or mid-RESP: immediate return to reset values; rsp_valid drops asynchronously.

Decomposition:
- Shared package/include: op code constants LU_OP_ZERO=2'b00, LU_OP_OR=2'b01, LU_OP_XOR=2'b10, LU_OP_AND=2'b11; FSM state encodings IDLE=2'b00, EXEC=2'b01, RESP=2'b10.
- Sub-module rr_pick: combinational. Inputs: req vector and ptr. Outputs: one-hot grant, grant index, any flag.
- The logic unit is instantiated by the parent, not inside this block.

Test Plan:
- Single request: req0 a=16'h00F0, b=16'h0FF0, op=01 -> ready0 in the accept cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_data=16'h0FF0.
- Op coverage on the same operands: op=10 -> 16'h0F00; op=11 -> 16'h00F0; op=00 -> 16'h0000.
- Round robin:
  - req0 and req1 held valid from reset, rsp_ready=1 -> grants alternate 0,1,0,1.
  - rsp_id sequence matches the grants; each response carries its own requester's operands.
- Backpressure:
  - rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data, rsp_id stable; req_ready stays 0; busy=1.
  - rsp_ready=1 -> accepted, IDLE next cycle.
- Reset mid-transaction: deassert rst_n in EXEC -> rsp_valid=0 and busy=0 immediately, no response produced; after release, req1-only request is granted with rr_ptr restarted at 0.
- Valid withdrawn: req1 valid for one cycle while busy, then dropped -> no grant to 1 and no spurious response.
